// File: rtl/armleocpu_avl_responder_if.sv
// Avalon-MM command/response bundle between an initiator and armleocpu_avl_responder.
interface armleocpu_avl_responder_if;
   logic [33:0] avl_address;
   logic        avl_read;
   logic        avl_write;
   logic [31:0] avl_writedata;
   logic [3:0]  avl_byteenable;
   logic        avl_waitrequest;
   logic        avl_readdatavalid;
   logic [31:0] avl_readdata;
   logic [1:0]  avl_response;

   modport master (
      output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
      input  avl_waitrequest, avl_readdatavalid, avl_readdata, avl_response
   );

   modport slave (
      input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
      output avl_waitrequest, avl_readdatavalid, avl_readdata, avl_response
   );
endinterface

// File: rtl/armleocpu_avl_responder.sv
// Avalon-MM word RAM responder with fixed read latency, decode-error range and a SLVERR window.
// Optional pseudo-random stalls are enabled by defining ARMLEOCPU_AVL_RESPONDER_STALL_EN.
module armleocpu_avl_responder #(
   parameter int DEPTH_LOG2    = 13,
   parameter int READ_LATENCY  = 1,
   parameter int ERR_BASE_WORD = 0,
   parameter int ERR_WORDS     = 0
) (
   input logic                      clk,
   input logic                      rst_n,
   armleocpu_avl_responder_if.slave avl
);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   logic [31:0]           mem [0:(1 << DEPTH_LOG2) - 1];
   logic [31:0]           word;
   logic [DEPTH_LOG2-1:0] mem_idx;
   logic [1:0]            cls;
   logic                  rd_accept;
   logic                  wr_accept;
   logic                  unused_addr_lsb;

   logic                  vld_p  [READ_LATENCY];
   logic [31:0]           data_p [READ_LATENCY];
   logic [1:0]            resp_p [READ_LATENCY];

   function automatic logic [1:0] classify(input logic [31:0] w);
      logic [32:0] lo;
      logic [32:0] hi;
      lo = 33'(ERR_BASE_WORD);
      hi = lo + 33'(ERR_WORDS);
      if ((w >> DEPTH_LOG2) != '0)
         classify = RESP_DECERR;
      else if ({1'b0, w} >= lo && {1'b0, w} < hi)
         classify = RESP_SLVERR;
      else
         classify = RESP_OKAY;
   endfunction

   assign word            = avl.avl_address[33:2];
   assign mem_idx         = word[DEPTH_LOG2-1:0];
   assign cls             = classify(word);
   assign unused_addr_lsb = ^avl.avl_address[1:0];

`ifdef ARMLEOCPU_AVL_RESPONDER_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (!rst_n)
         lfsr <= 16'hACE1;
      else
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign avl.avl_waitrequest = !rst_n || (lfsr[1:0] == 2'b00);
`else
   assign avl.avl_waitrequest = !rst_n;
`endif

   // A simultaneous read wins; the write half of such a command is dropped.
   assign rd_accept = avl.avl_read && !avl.avl_waitrequest;
   assign wr_accept = avl.avl_write && !avl.avl_read && !avl.avl_waitrequest;

   always_ff @(posedge clk) begin
      if (wr_accept && cls == RESP_OKAY) begin
         for (int b = 0; b < 4; b++) begin
            if (avl.avl_byteenable[b])
               mem[mem_idx][8*b +: 8] <= avl.avl_writedata[8*b +: 8];
         end
      end
   end

   // Stage 0 captures the read; later stages only move when carrying a response so the
   // final stage holds its last data/response between pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            vld_p[i]  <= 1'b0;
            data_p[i] <= '0;
            resp_p[i] <= RESP_OKAY;
         end
      end else begin
         vld_p[0] <= rd_accept;
         if (rd_accept) begin
            data_p[0] <= (cls == RESP_OKAY) ? mem[mem_idx] : '0;
            resp_p[0] <= cls;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_p[i] <= vld_p[i-1];
            if (vld_p[i-1]) begin
               data_p[i] <= data_p[i-1];
               resp_p[i] <= resp_p[i-1];
            end
         end
      end
   end

   assign avl.avl_readdatavalid = vld_p[READ_LATENCY-1];
   assign avl.avl_readdata      = data_p[READ_LATENCY-1];
   assign avl.avl_response      = resp_p[READ_LATENCY-1];
endmodule

// File: tb/tb_armleocpu_avl_responder.sv
// Bench for armleocpu_avl_responder: three instances (latency 1, 3, 4) share one command stream
// and are scored against a queue-based reference model.
module tb_armleocpu_avl_responder;
   localparam int N        = 3;
   localparam int ERR_BASE = 1;
   localparam int ERR_W    = 1;

   typedef struct {
      int          acc;
      logic [31:0] data;
      logic [1:0]  resp;
   } rsp_t;

   logic        clk;
   logic        rst_n;
   logic [33:0] address;
   logic        rd;
   logic        wr;
   logic [31:0] wdata;
   logic [3:0]  be;

   armleocpu_avl_responder_if if0 ();
   armleocpu_avl_responder_if if1 ();
   armleocpu_avl_responder_if if2 ();

   assign if0.avl_address = address; assign if0.avl_read = rd; assign if0.avl_write = wr;
   assign if0.avl_writedata = wdata; assign if0.avl_byteenable = be;
   assign if1.avl_address = address; assign if1.avl_read = rd; assign if1.avl_write = wr;
   assign if1.avl_writedata = wdata; assign if1.avl_byteenable = be;
   assign if2.avl_address = address; assign if2.avl_read = rd; assign if2.avl_write = wr;
   assign if2.avl_writedata = wdata; assign if2.avl_byteenable = be;

   logic        wait_o [N];
   logic        vld_o  [N];
   logic [31:0] data_o [N];
   logic [1:0]  resp_o [N];

   assign wait_o[0] = if0.avl_waitrequest; assign vld_o[0] = if0.avl_readdatavalid;
   assign data_o[0] = if0.avl_readdata;    assign resp_o[0] = if0.avl_response;
   assign wait_o[1] = if1.avl_waitrequest; assign vld_o[1] = if1.avl_readdatavalid;
   assign data_o[1] = if1.avl_readdata;    assign resp_o[1] = if1.avl_response;
   assign wait_o[2] = if2.avl_waitrequest; assign vld_o[2] = if2.avl_readdatavalid;
   assign data_o[2] = if2.avl_readdata;    assign resp_o[2] = if2.avl_response;

   armleocpu_avl_responder #(.DEPTH_LOG2(13), .READ_LATENCY(1), .ERR_BASE_WORD(ERR_BASE), .ERR_WORDS(ERR_W))
      dut0 (.clk(clk), .rst_n(rst_n), .avl(if0));
   armleocpu_avl_responder #(.DEPTH_LOG2(13), .READ_LATENCY(3), .ERR_BASE_WORD(ERR_BASE), .ERR_WORDS(ERR_W))
      dut1 (.clk(clk), .rst_n(rst_n), .avl(if1));
   armleocpu_avl_responder #(.DEPTH_LOG2(13), .READ_LATENCY(4), .ERR_BASE_WORD(ERR_BASE), .ERR_WORDS(ERR_W))
      dut2 (.clk(clk), .rst_n(rst_n), .avl(if2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   rsp_t        pend [$];
   logic [31:0] mem_m [longint];
   logic [15:0] lfsr_m = 16'hACE1;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        last_acc;
   logic [31:0] exp_data  [N];
   logic [1:0]  exp_resp  [N];
   int          vld_cnt   [N];
   logic [31:0] last_data [N];
   logic [1:0]  last_resp [N];

   function automatic int lat(input int i);
      return (i == 0) ? 1 : (i == 1) ? 3 : 4;
   endfunction

   function automatic logic [1:0] ref_class(input longint w);
      if (w >= 8192) return 2'b11;
      if (w >= ERR_BASE && w < ERR_BASE + ERR_W) return 2'b10;
      return 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   // One clock: predict waitrequest/acceptance, advance the model at the edge, score outputs.
   task automatic step_cycle();
      logic        exp_wait;
      logic        exp_v;
      longint      w;
      logic [1:0]  c;
      logic [31:0] mask;
      #1;
`ifdef ARMLEOCPU_AVL_RESPONDER_STALL_EN
      exp_wait = !rst_n || (lfsr_m[1:0] == 2'b00);
`else
      exp_wait = !rst_n;
`endif
      for (int i = 0; i < N; i++) chk($sformatf("waitrequest[%0d]", i), wait_o[i], exp_wait);
      last_acc = rst_n && (rd || wr) && !exp_wait;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         pend.delete();
         lfsr_m = 16'hACE1;
         for (int i = 0; i < N; i++) begin
            exp_data[i] = '0;
            exp_resp[i] = 2'b00;
         end
      end else begin
         lfsr_m = {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
         if (last_acc) begin
            w = longint'(address[33:2]);
            c = ref_class(w);
            if (rd) begin
               pend.push_back('{acc: cyc, data: (c == 2'b00) ? mem_m[w] : 32'h0, resp: c});
            end else if (c == 2'b00) begin
               mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
               mem_m[w] = ((mem_m.exists(w) ? mem_m[w] : 32'h0) & ~mask) | (wdata & mask);
            end
         end
      end
      #1;
      for (int i = 0; i < N; i++) begin
         exp_v = 1'b0;
         foreach (pend[k]) begin
            if (pend[k].acc + lat(i) - 1 == cyc) begin
               exp_v       = 1'b1;
               exp_data[i] = pend[k].data;
               exp_resp[i] = pend[k].resp;
            end
         end
         chk($sformatf("readdatavalid[%0d]", i), vld_o[i], exp_v);
         chk($sformatf("readdata[%0d]", i), data_o[i], exp_data[i]);
         chk($sformatf("response[%0d]", i), resp_o[i], exp_resp[i]);
         if (vld_o[i] === 1'b1) begin
            vld_cnt[i]++;
            last_data[i] = data_o[i];
            last_resp[i] = resp_o[i];
         end
      end
      while (pend.size() > 0 && pend[0].acc + 3 <= cyc) void'(pend.pop_front());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step_cycle();
   endtask

   // Holds the command until it is accepted, then drops it so it is taken exactly once.
   task automatic do_cmd(input logic r, input logic wv, input logic [33:0] a,
                         input logic [31:0] d, input logic [3:0] b);
      int n;
      rd = r; wr = wv; address = a; wdata = d; be = b;
      n = 0;
      do begin
         step_cycle();
         n++;
      end while (!last_acc && n < 64);
      chk("command_accepted", last_acc, 1'b1);
      rd = 1'b0; wr = 1'b0;
   endtask

   task automatic expect_last(input string tag, input logic [31:0] d, input logic [1:0] r);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s_data[%0d]", tag, i), last_data[i], d);
         chk($sformatf("%s_resp[%0d]", tag, i), last_resp[i], r);
      end
   endtask

   initial begin
      int          saved;
      logic [31:0] w;
      rst_n = 1'b0; rd = 1'b0; wr = 1'b0; address = '0; wdata = '0; be = '0;
      for (int i = 0; i < N; i++) begin
         vld_cnt[i] = 0; last_data[i] = '0; last_resp[i] = '0;
         exp_data[i] = '0; exp_resp[i] = '0;
      end
      idle(3);
      rst_n = 1'b1;
      idle(2);

      for (int k = 0; k < 32; k++) begin
         if (k == 3)      do_cmd(1'b0, 1'b1, 34'(k) << 2, 32'hDEADBEEF, 4'hF);
         else if (k == 8) do_cmd(1'b0, 1'b1, 34'(k) << 2, 32'h0, 4'hF);
         else if (k != 1) do_cmd(1'b0, 1'b1, 34'(k) << 2, $urandom(), 4'hF);
      end

      do_cmd(1'b1, 1'b0, 34'hC, '0, '0);
      idle(6);
      expect_last("simple_read", 32'hDEADBEEF, 2'b00);

      do_cmd(1'b1, 1'b0, 34'h4, '0, '0);
      idle(6);
      expect_last("fault_read", 32'h0, 2'b10);
      do_cmd(1'b0, 1'b1, 34'h4, 32'h1234, 4'hF);
      do_cmd(1'b1, 1'b0, 34'h4, '0, '0);
      idle(6);
      expect_last("fault_after_write", 32'h0, 2'b10);

      do_cmd(1'b1, 1'b0, 34'h8000, '0, '0);
      idle(6);
      expect_last("decode_error", 32'h0, 2'b11);

      saved = vld_cnt[1];
      do_cmd(1'b1, 1'b0, 34'h14, '0, '0);
      do_cmd(1'b1, 1'b0, 34'h18, '0, '0);
      do_cmd(1'b1, 1'b0, 34'h1C, '0, '0);
      idle(6);
      chk("ordering_count", 32'(vld_cnt[1] - saved), 32'd3);
      chk("ordering_last", last_data[1], mem_m[7]);

      do_cmd(1'b0, 1'b1, 34'h20, 32'hFFFFFFFF, 4'b0101);
      do_cmd(1'b1, 1'b0, 34'h20, '0, '0);
      idle(6);
      expect_last("byteenable_hazard", 32'h00FF00FF, 2'b00);

      saved = vld_cnt[2];
      do_cmd(1'b1, 1'b0, 34'hC, '0, '0);
      step_cycle();
      rst_n = 1'b0;
      step_cycle();
      rst_n = 1'b1;
      idle(8);
      chk("reset_drops_inflight", 32'(vld_cnt[2] - saved), 32'd0);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0) w = 32'h2000 + 32'($urandom_range(0, 32'hFFFF));
         else                           w = 32'($urandom_range(0, 31));
         if ($urandom_range(0, 2) == 0)
            do_cmd(1'b0, 1'b1, {w, 2'($urandom_range(0, 3))}, $urandom(), 4'($urandom_range(0, 15)));
         else
            do_cmd(1'b1, 1'b0, {w, 2'($urandom_range(0, 3))}, '0, '0);
         idle($urandom_range(0, 2));
      end
      idle(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
